// File: rtl/mode_counter_pkg.sv
// Shared definitions for the multi-mode counter: mode encodings and default width.
package mode_counter_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_UP3  = 2'b00,
        MODE_DN1  = 2'b01,
        MODE_UP1  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/mode_counter_next.sv
// Combinational next-value logic: next count, wrap flag and load flag from the current count, mode and D.
module mode_counter_next
    import mode_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]  q_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [WIDTH-1:0]  d_i,
    output logic [WIDTH-1:0]  q_next_c,
    output logic              rco_next_c,
    output logic              load_next_c
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [SUM_W-1:0] sum;

    // Up-counts use a one-bit-wider sum so the top bit is the carry; unlisted modes hold.
    always_comb begin
        sum         = '0;
        q_next_c    = q_i;
        rco_next_c  = 1'b0;
        load_next_c = 1'b0;
        case (mode_i)
            MODE_UP3: begin
                sum        = {1'b0, q_i} + SUM_W'(3);
                q_next_c   = sum[WIDTH-1:0];
                rco_next_c = sum[WIDTH];
            end
            MODE_DN1: begin
                q_next_c   = q_i - WIDTH'(1);
                rco_next_c = (q_i == '0);
            end
            MODE_UP1: begin
                sum        = {1'b0, q_i} + SUM_W'(1);
                q_next_c   = sum[WIDTH-1:0];
                rco_next_c = sum[WIDTH];
            end
            MODE_LOAD: begin
                q_next_c    = d_i;
                load_next_c = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mode_counter.sv
// 4-bit multi-mode counter (up3 / down1 / up1 / load) with registered count, wrap and load flags.
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  D,
    output logic [WIDTH-1:0]  Q,
    output logic              rco,
    output logic              load
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    logic             load_q, load_d;

    logic [WIDTH-1:0] q_next;
    logic             rco_next;
    logic             load_next;

    mode_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q_i         (q_q),
        .mode_i      (mode),
        .d_i         (D),
        .q_next_c    (q_next),
        .rco_next_c  (rco_next),
        .load_next_c (load_next)
    );

    // Disabled cycles hold the count and drop both one-cycle flags.
    always_comb begin
        q_d    = q_q;
        rco_d  = 1'b0;
        load_d = 1'b0;
        if (enable) begin
            q_d    = q_next;
            rco_d  = rco_next;
            load_d = load_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q    <= '0;
            rco_q  <= 1'b0;
            load_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rco_q  <= rco_d;
            load_q <= load_d;
        end
    end

    assign Q    = q_q;
    assign rco  = rco_q;
    assign load = load_q;

endmodule

// File: tb/tb_mode_counter.sv
// Bench for mode_counter: directed steps plus random traffic against an arithmetic reference model.
module tb_mode_counter;

    localparam int W    = 4;
    localparam int MODV = 1 << W;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [1:0]   mode;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic         rco;
    logic         load;

    int n_vec = 0;
    int n_err = 0;

    int m_q    = 0;
    int m_rco  = 0;
    int m_load = 0;

    mode_counter dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .D      (D),
        .Q      (Q),
        .rco    (rco),
        .load   (load)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the mode rules, in plain integer arithmetic.
    task automatic model(input int rst_n, input int en, input int m, input int d);
        int s;
        m_rco  = 0;
        m_load = 0;
        if (rst_n == 0) begin
            m_q = 0;
        end else if (en != 0) begin
            case (m)
                0: begin s = m_q + 3; m_rco = (s > MODV - 1) ? 1 : 0; m_q = s % MODV; end
                1: begin m_rco = (m_q == 0) ? 1 : 0; m_q = (m_q + MODV - 1) % MODV; end
                2: begin s = m_q + 1; m_rco = (s > MODV - 1) ? 1 : 0; m_q = s % MODV; end
                default: begin m_q = d; m_load = 1; end
            endcase
        end
    endtask

    task automatic apply(input string tag, input int rst_n, input int en, input int m, input int d);
        @(negedge clk);
        reset  = 1'(rst_n);
        enable = 1'(en);
        mode   = 2'(m);
        D      = W'(d);
        model(rst_n, en, m, d);
        @(posedge clk);
        #1;
        check($sformatf("%s_q", tag),    8'(Q),    8'(m_q));
        check($sformatf("%s_rco", tag),  8'(rco),  8'(m_rco));
        check($sformatf("%s_load", tag), 8'(load), 8'(m_load));
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        mode   = 2'b00;
        D      = '0;

        apply("reset0", 0, 1, 0, 0);
        apply("reset1", 0, 1, 0, 0);
        check("reset_q_const", 8'(Q), 8'd0);

        for (int i = 0; i < 16; i++) apply($sformatf("up1_%0d", i), 1, 1, 2, 0);
        check("up1_wrap_q_const", 8'(Q), 8'd0);

        for (int i = 0; i < 6; i++) apply($sformatf("up3_%0d", i), 1, 1, 0, 0);
        check("up3_wrap_q_const", 8'(Q), 8'd2);

        for (int i = 0; i < 3; i++) apply($sformatf("dn1_%0d", i), 1, 1, 1, 0);
        check("dn1_wrap_q_const", 8'(Q), 8'd15);

        apply("load_a", 1, 1, 3, 10);
        check("load_a_q_const", 8'(Q), 8'd10);
        for (int i = 0; i < 3; i++)
            apply($sformatf("hold_%0d", i), 1, 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        check("hold_q_const", 8'(Q), 8'd10);

        apply("load_7", 1, 1, 3, 7);
        apply("midrst", 0, 1, 2, 0);
        apply("resume", 1, 1, 2, 0);
        check("resume_q_const", 8'(Q), 8'd1);

        for (int i = 0; i < 300; i++) begin
            int r;
            r = ($urandom_range(0, 24) == 0) ? 0 : 1;
            apply($sformatf("rnd_%0d", i), r, int'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
